// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the responder (slave).
// Request uses valid/ready; the response is a one-cycle valid pulse with data and error.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Doubleword data-memory responder: accept when idle, respond WAIT_CYCLES+1 cycles later; req_ready low while busy, nothing queued.
// Optional fault reporting (misaligned / out of range) is enabled with the DMEM_ERR_EN macro.
module dmem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic [63:0]     wdata_q;
  logic            err_q;
  logic [63:0]     mem_q [DEPTH];

  logic            accept;
  logic [AW-1:0]   req_idx;
  logic            req_fault;
  logic            enter_resp;
  logic            from_bus;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [63:0]     mem_wdat;

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign req_idx = bus.req_addr[AW+2:3];

`ifdef DMEM_ERR_EN
  assign req_fault = (bus.req_addr[2:0] != 3'd0) ||
                     ((bus.req_addr >> (AW + 3)) != 64'd0);
`else
  // Without fault reporting the low and high address bits are simply dropped.
  logic unused_addr_bits;
  assign req_fault        = 1'b0;
  assign unused_addr_bits = ^{bus.req_addr[63:AW+3], bus.req_addr[2:0]};
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 64'd0;
    bus.resp_err   = 1'b0;
    case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!wr_q && !err_q) bus.resp_rdata = mem_q[idx_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= bus.req_write;
      idx_q   <= req_idx;
      wdata_q <= bus.req_wdata;
      err_q   <= req_fault;
    end
  end

  // Store commits on the edge entering RESP; with zero wait states that is the accept edge itself.
  assign enter_resp = (state_q != S_RESP) && (state_d == S_RESP);
  assign from_bus   = (state_q == S_IDLE);
  assign mem_we     = enter_resp && (from_bus ? (bus.req_write && !req_fault) : (wr_q && !err_q));
  assign mem_widx   = from_bus ? req_idx : idx_q;
  assign mem_wdat   = from_bus ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'd0;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdat;
    end
  end
endmodule
